// File: rtl/rs_param.sv
// rs_param: out-of-order reservation station with age-matrix ordering,
// CDB wakeup, per-FU-class issue budgets and squash.
// Dispatch/issue handshake: lane k may dispatch only when o_disp_stall[k]
// is 0 (registered free count); a lane asserted while stalled is dropped.
// Issue has no back-pressure: o_issue_valid[s] marks a slot holding an
// entry that has already left the station.
module rs_param #(
  parameter int ENTRIES   = 16,
  parameter int DISP_W    = 3,
  parameter int ISSUE_W   = 3,
  parameter int CDB_W     = 3,
  parameter int PR_W      = 6,
  parameter int FU_TYPES  = 4,
  parameter int PAYLOAD_W = 64,
  parameter int FT_W      = (FU_TYPES > 1) ? $clog2(FU_TYPES) : 1,
  parameter int BUD_W     = $clog2(ISSUE_W + 1),
  parameter int CNT_W     = $clog2(ENTRIES + 1)
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [DISP_W-1:0]            i_disp_valid,
  input  logic [DISP_W*FT_W-1:0]       i_disp_fu_type,
  input  logic [DISP_W*PR_W-1:0]       i_disp_reg1_pr,
  input  logic [DISP_W*PR_W-1:0]       i_disp_reg2_pr,
  input  logic [DISP_W-1:0]            i_disp_reg1_ready,
  input  logic [DISP_W-1:0]            i_disp_reg2_ready,
  input  logic [DISP_W*PAYLOAD_W-1:0]  i_disp_payload,
  output logic [DISP_W-1:0]            o_disp_stall,
  input  logic [CDB_W-1:0]             i_cdb_valid,
  input  logic [CDB_W*PR_W-1:0]        i_cdb_tag,
  input  logic [FU_TYPES*BUD_W-1:0]    i_fu_budget,
  input  logic                         i_squash,
  output logic [ISSUE_W-1:0]           o_issue_valid,
  output logic [ISSUE_W*FT_W-1:0]      o_issue_fu_type,
  output logic [ISSUE_W*PR_W-1:0]      o_issue_reg1_pr,
  output logic [ISSUE_W*PR_W-1:0]      o_issue_reg2_pr,
  output logic [ISSUE_W*PAYLOAD_W-1:0] o_issue_payload,
  output logic [CNT_W-1:0]             o_free_cnt
);
  localparam int EW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int LW = (DISP_W > 1) ? $clog2(DISP_W) : 1;

  // Entry storage; r_older[i][j]=1 means entry i was dispatched before j.
  logic [ENTRIES-1:0]   r_valid, r_rdy1, r_rdy2;
  logic [FT_W-1:0]      r_fu_type [ENTRIES];
  logic [PR_W-1:0]      r_pr1 [ENTRIES];
  logic [PR_W-1:0]      r_pr2 [ENTRIES];
  logic [PAYLOAD_W-1:0] r_payload [ENTRIES];
  logic [ENTRIES-1:0]   r_older [ENTRIES];
  logic [CNT_W-1:0]     r_free_cnt;

  logic [ENTRIES-1:0] w_alloc_mask;
  logic [LW-1:0]      w_alloc_lane [ENTRIES];
  logic [EW-1:0]      w_lane_idx [DISP_W];
  logic [DISP_W-1:0]  w_lane_go;
  logic [CNT_W-1:0]   w_n_alloc;
  logic               w_found;
  logic [ENTRIES-1:0] w_older_nxt [ENTRIES];
  logic [ENTRIES-1:0] w_elig;
  logic [CNT_W-1:0]   w_rank [ENTRIES];
  logic [ENTRIES-1:0] w_take;
  logic [ISSUE_W-1:0] w_slot_vld;
  logic [EW-1:0]      w_slot_idx [ISSUE_W];
  logic [BUD_W-1:0]   w_used [FU_TYPES];
  logic [BUD_W-1:0]   w_n_take;
  logic               w_hit;
  logic [EW-1:0]      w_cand;
  logic [FT_W-1:0]    w_cls;

  assign o_free_cnt = r_free_cnt;

  // True when any valid CDB slot carries the given tag.
  function automatic logic f_wake(input logic [PR_W-1:0] tag,
                                  input logic [CDB_W-1:0] vld,
                                  input logic [CDB_W*PR_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_W; c++)
      if (vld[c] && (tags[c*PR_W +: PR_W] == tag)) hit = 1'b1;
    return hit;
  endfunction

  // Stall depends only on the registered free count.
  always_comb begin
    o_disp_stall = '0;
    for (int k = 0; k < DISP_W; k++)
      o_disp_stall[k] = (r_free_cnt < CNT_W'(k + 1));
  end

  // Each accepted lane claims the lowest free entry not already claimed.
  always_comb begin
    w_alloc_mask = '0;
    w_lane_go    = '0;
    w_n_alloc    = '0;
    w_found      = 1'b0;
    for (int e = 0; e < ENTRIES; e++) w_alloc_lane[e] = '0;
    for (int k = 0; k < DISP_W; k++) w_lane_idx[k] = '0;
    for (int k = 0; k < DISP_W; k++) begin
      w_found = 1'b0;
      if (i_disp_valid[k] && !o_disp_stall[k] && !i_squash) begin
        for (int e = 0; e < ENTRIES; e++) begin
          if (!w_found && !r_valid[e] && !w_alloc_mask[e]) begin
            w_found         = 1'b1;
            w_alloc_mask[e] = 1'b1;
            w_alloc_lane[e] = LW'(k);
            w_lane_idx[k]   = EW'(e);
          end
        end
        w_lane_go[k] = w_found;
        w_n_alloc    = w_n_alloc + CNT_W'(w_found);
      end
    end
  end

  // New entries are younger than every valid entry and every lower lane.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) w_older_nxt[i] = r_older[i];
    for (int k = 0; k < DISP_W; k++) begin
      if (w_lane_go[k]) begin
        for (int j = 0; j < ENTRIES; j++) begin
          w_older_nxt[w_lane_idx[k]][j] = 1'b0;
          w_older_nxt[j][w_lane_idx[k]] = r_valid[j];
        end
        for (int l = 0; l < k; l++)
          if (w_lane_go[l]) w_older_nxt[w_lane_idx[l]][w_lane_idx[k]] = 1'b1;
      end
    end
  end

  // Age rank among eligible entries: number of older eligible entries.
  always_comb begin
    w_elig = r_valid & r_rdy1 & r_rdy2;
    for (int i = 0; i < ENTRIES; i++) begin
      w_rank[i] = '0;
      for (int j = 0; j < ENTRIES; j++)
        if (w_elig[j] && r_older[j][i]) w_rank[i] = w_rank[i] + CNT_W'(1);
    end
  end

  // Oldest-first selection under the slot limit and per-class budgets.
  always_comb begin
    w_take     = '0;
    w_slot_vld = '0;
    w_n_take   = '0;
    w_hit      = 1'b0;
    w_cand     = '0;
    w_cls      = '0;
    for (int s = 0; s < ISSUE_W; s++) w_slot_idx[s] = '0;
    for (int f = 0; f < FU_TYPES; f++) w_used[f] = '0;
    for (int r = 0; r < ENTRIES; r++) begin
      w_hit  = 1'b0;
      w_cand = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_elig[i] && (w_rank[i] == CNT_W'(r))) begin
          w_hit  = 1'b1;
          w_cand = EW'(i);
        end
      end
      w_cls = r_fu_type[w_cand];
      if (w_hit && (w_n_take < BUD_W'(ISSUE_W)) &&
          (w_used[w_cls] < i_fu_budget[int'(w_cls)*BUD_W +: BUD_W])) begin
        w_take[w_cand] = 1'b1;
        for (int s = 0; s < ISSUE_W; s++) begin
          if (BUD_W'(s) == w_n_take) begin
            w_slot_vld[s] = 1'b1;
            w_slot_idx[s] = w_cand;
          end
        end
        w_used[w_cls] = w_used[w_cls] + BUD_W'(1);
        w_n_take      = w_n_take + BUD_W'(1);
      end
    end
  end

  // Entry state: allocation, wakeup, issue release, squash and reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_valid    <= '0;
      r_rdy1     <= '0;
      r_rdy2     <= '0;
      r_free_cnt <= CNT_W'(ENTRIES);
      for (int e = 0; e < ENTRIES; e++) begin
        r_fu_type[e] <= '0;
        r_pr1[e]     <= '0;
        r_pr2[e]     <= '0;
        r_payload[e] <= '0;
        r_older[e]   <= '0;
      end
    end else if (i_squash) begin
      r_valid    <= '0;
      r_free_cnt <= CNT_W'(ENTRIES);
    end else begin
      r_valid    <= (r_valid & ~w_take) | w_alloc_mask;
      r_free_cnt <= r_free_cnt - w_n_alloc + CNT_W'(w_n_take);
      for (int e = 0; e < ENTRIES; e++) begin
        r_older[e] <= w_older_nxt[e];
        if (w_alloc_mask[e]) begin
          r_fu_type[e] <= i_disp_fu_type[int'(w_alloc_lane[e])*FT_W +: FT_W];
          r_pr1[e]     <= i_disp_reg1_pr[int'(w_alloc_lane[e])*PR_W +: PR_W];
          r_pr2[e]     <= i_disp_reg2_pr[int'(w_alloc_lane[e])*PR_W +: PR_W];
          r_payload[e] <= i_disp_payload[int'(w_alloc_lane[e])*PAYLOAD_W +: PAYLOAD_W];
          r_rdy1[e]    <= i_disp_reg1_ready[w_alloc_lane[e]] |
                          f_wake(i_disp_reg1_pr[int'(w_alloc_lane[e])*PR_W +: PR_W],
                                 i_cdb_valid, i_cdb_tag);
          r_rdy2[e]    <= i_disp_reg2_ready[w_alloc_lane[e]] |
                          f_wake(i_disp_reg2_pr[int'(w_alloc_lane[e])*PR_W +: PR_W],
                                 i_cdb_valid, i_cdb_tag);
        end else begin
          r_rdy1[e] <= r_rdy1[e] | f_wake(r_pr1[e], i_cdb_valid, i_cdb_tag);
          r_rdy2[e] <= r_rdy2[e] | f_wake(r_pr2[e], i_cdb_valid, i_cdb_tag);
        end
      end
    end
  end

  // Issue register: selected entries in age order, unused slots zeroed.
  always_ff @(posedge i_clock) begin
    if (!i_reset || i_squash) begin
      o_issue_valid   <= '0;
      o_issue_fu_type <= '0;
      o_issue_reg1_pr <= '0;
      o_issue_reg2_pr <= '0;
      o_issue_payload <= '0;
    end else begin
      o_issue_valid <= w_slot_vld;
      for (int s = 0; s < ISSUE_W; s++) begin
        o_issue_fu_type[s*FT_W +: FT_W] <=
          w_slot_vld[s] ? r_fu_type[w_slot_idx[s]] : '0;
        o_issue_reg1_pr[s*PR_W +: PR_W] <=
          w_slot_vld[s] ? r_pr1[w_slot_idx[s]] : '0;
        o_issue_reg2_pr[s*PR_W +: PR_W] <=
          w_slot_vld[s] ? r_pr2[w_slot_idx[s]] : '0;
        o_issue_payload[s*PAYLOAD_W +: PAYLOAD_W] <=
          w_slot_vld[s] ? r_payload[w_slot_idx[s]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_rs_param.sv
// Directed testbench for rs_param: reset, basic dispatch/issue, full-station
// stall and CDB wakeup, per-class budgets, same-cycle CDB bypass, squash.
module tb_rs_param;
  localparam int DISP_W = 3, ISSUE_W = 3, CDB_W = 3, PR_W = 6;
  localparam int FT_W = 2, BUD_W = 2, CNT_W = 5, PAYLOAD_W = 64, FU_TYPES = 4;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic [DISP_W-1:0]            disp_valid;
  logic [DISP_W*FT_W-1:0]       disp_fu_type;
  logic [DISP_W*PR_W-1:0]       disp_reg1_pr, disp_reg2_pr;
  logic [DISP_W-1:0]            disp_reg1_ready, disp_reg2_ready;
  logic [DISP_W*PAYLOAD_W-1:0]  disp_payload;
  logic [DISP_W-1:0]            disp_stall;
  logic [CDB_W-1:0]             cdb_valid;
  logic [CDB_W*PR_W-1:0]        cdb_tag;
  logic [FU_TYPES*BUD_W-1:0]    fu_budget;
  logic                         squash;
  logic [ISSUE_W-1:0]           issue_valid;
  logic [ISSUE_W*FT_W-1:0]      issue_fu_type;
  logic [ISSUE_W*PR_W-1:0]      issue_reg1_pr, issue_reg2_pr;
  logic [ISSUE_W*PAYLOAD_W-1:0] issue_payload;
  logic [CNT_W-1:0]             free_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [PAYLOAD_W-1:0] exp_q[$];

  rs_param dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_disp_valid(disp_valid), .i_disp_fu_type(disp_fu_type),
    .i_disp_reg1_pr(disp_reg1_pr), .i_disp_reg2_pr(disp_reg2_pr),
    .i_disp_reg1_ready(disp_reg1_ready), .i_disp_reg2_ready(disp_reg2_ready),
    .i_disp_payload(disp_payload), .o_disp_stall(disp_stall),
    .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag), .i_fu_budget(fu_budget),
    .i_squash(squash), .o_issue_valid(issue_valid),
    .o_issue_fu_type(issue_fu_type), .o_issue_reg1_pr(issue_reg1_pr),
    .o_issue_reg2_pr(issue_reg2_pr), .o_issue_payload(issue_payload),
    .o_free_cnt(free_cnt)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    disp_valid      = '0;
    disp_fu_type    = '0;
    disp_reg1_pr    = '0;
    disp_reg2_pr    = '0;
    disp_reg1_ready = '0;
    disp_reg2_ready = '0;
    disp_payload    = '0;
    cdb_valid       = '0;
    cdb_tag         = '0;
    squash          = 1'b0;
  endtask

  task automatic set_lane(input int k, input logic [FT_W-1:0] fu,
                          input logic [PR_W-1:0] p1, input logic r1,
                          input logic [PR_W-1:0] p2, input logic r2,
                          input logic [PAYLOAD_W-1:0] pl);
    disp_valid[k]                          = 1'b1;
    disp_fu_type[k*FT_W +: FT_W]           = fu;
    disp_reg1_pr[k*PR_W +: PR_W]           = p1;
    disp_reg1_ready[k]                     = r1;
    disp_reg2_pr[k*PR_W +: PR_W]           = p2;
    disp_reg2_ready[k]                     = r2;
    disp_payload[k*PAYLOAD_W +: PAYLOAD_W] = pl;
  endtask

  task automatic test_reset;
    clear_inputs();
    fu_budget = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (free_cnt !== 5'd16) begin
      n_fail++; $display("FAIL reset_free_cnt: got %0d expected 16", free_cnt);
    end
    n_tests++;
    if (disp_stall !== 3'b000) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 000", disp_stall);
    end
    n_tests++;
    if (issue_valid !== 3'b000 || issue_payload !== '0) begin
      n_fail++; $display("FAIL reset_issue: valid %b payload %h expected zero", issue_valid, issue_payload);
    end
  endtask

  task automatic test_dispatch_issue;
    fu_budget = 8'h03;
    clear_inputs();
    for (int k = 0; k < 3; k++) set_lane(k, 2'd0, 6'd1, 1'b1, 6'd2, 1'b1, 64'h100 + 64'(k));
    tick();
    clear_inputs();
    n_tests++;
    if (free_cnt !== 5'd13 || issue_valid !== 3'b000) begin
      n_fail++; $display("FAIL basic_after_dispatch: free %0d valid %b expected 13 000", free_cnt, issue_valid);
    end
    tick();
    n_tests++;
    if (issue_valid !== 3'b111) begin
      n_fail++; $display("FAIL basic_issue_valid: got %b expected 111", issue_valid);
    end
    for (int s = 0; s < 3; s++) begin
      n_tests++;
      if (issue_payload[s*PAYLOAD_W +: PAYLOAD_W] !== 64'h100 + 64'(s) ||
          issue_reg1_pr[s*PR_W +: PR_W] !== 6'd1 || issue_reg2_pr[s*PR_W +: PR_W] !== 6'd2) begin
        n_fail++; $display("FAIL basic_slot%0d: payload %h expected %h", s,
                           issue_payload[s*PAYLOAD_W +: PAYLOAD_W], 64'h100 + 64'(s));
      end
    end
    n_tests++;
    if (free_cnt !== 5'd16) begin
      n_fail++; $display("FAIL basic_free_back: got %0d expected 16", free_cnt);
    end
    tick();
    n_tests++;
    if (issue_valid !== 3'b000) begin
      n_fail++; $display("FAIL basic_idle: got %b expected 000", issue_valid);
    end
  endtask

  task automatic test_full_wakeup;
    int n;
    int rem;
    logic [2:0] exp_mask;
    logic [PAYLOAD_W-1:0] exp_pl;
    fu_budget = 8'hFF;
    n = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 6; cyc++) begin
      clear_inputs();
      for (int k = 0; k < 3; k++) begin
        if (n < 16) begin
          set_lane(k, 2'd0, 6'd5, 1'b0, 6'd7, 1'b1, 64'd200 + 64'(n));
          exp_q.push_back(64'd200 + 64'(n));
          n++;
        end
      end
      tick();
    end
    clear_inputs();
    n_tests++;
    if (free_cnt !== 5'd0 || disp_stall !== 3'b111 || issue_valid !== 3'b000) begin
      n_fail++; $display("FAIL full_stall: free %0d stall %b valid %b expected 0 111 000", free_cnt, disp_stall, issue_valid);
    end
    // Dispatch while stalled (dropped) and broadcast tag 5 on invalid slots
    for (int k = 0; k < 3; k++) set_lane(k, 2'd0, 6'd1, 1'b1, 6'd1, 1'b1, 64'hDEAD);
    cdb_tag = {6'd5, 6'd5, 6'd5};
    tick();
    tick();
    clear_inputs();
    n_tests++;
    if (issue_valid !== 3'b000 || free_cnt !== 5'd0) begin
      n_fail++; $display("FAIL full_no_wake: valid %b free %0d expected 000 0", issue_valid, free_cnt);
    end
    cdb_valid = 3'b001;
    cdb_tag[PR_W-1:0] = 6'd5;
    tick();
    clear_inputs();
    n_tests++;
    if (issue_valid !== 3'b000) begin
      n_fail++; $display("FAIL wake_same_cycle: got %b expected 000", issue_valid);
    end
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      rem = exp_q.size();
      exp_mask = (rem >= 3) ? 3'b111 : (rem == 2) ? 3'b011 : (rem == 1) ? 3'b001 : 3'b000;
      n_tests++;
      if (issue_valid !== exp_mask) begin
        n_fail++; $display("FAIL drain_valid cyc%0d: got %b expected %b", cyc, issue_valid, exp_mask);
      end
      for (int s = 0; s < 3; s++) begin
        if (exp_mask[s]) begin
          exp_pl = exp_q.pop_front();
          n_tests++;
          if (issue_payload[s*PAYLOAD_W +: PAYLOAD_W] !== exp_pl) begin
            n_fail++; $display("FAIL drain_payload cyc%0d slot%0d: got %0d expected %0d", cyc, s,
                               issue_payload[s*PAYLOAD_W +: PAYLOAD_W], exp_pl);
          end
        end
      end
      if (cyc == 0) begin
        n_tests++;
        if (free_cnt !== 5'd3 || disp_stall !== 3'b000) begin
          n_fail++; $display("FAIL drain_first_free: free %0d stall %b expected 3 000", free_cnt, disp_stall);
        end
      end
    end
    n_tests++;
    if (free_cnt !== 5'd16) begin
      n_fail++; $display("FAIL drain_free_end: got %0d expected 16", free_cnt);
    end
  endtask

  task automatic test_budget;
    fu_budget = '0;
    clear_inputs();
    set_lane(0, 2'd1, 6'd1, 1'b1, 6'd1, 1'b1, 64'hA);
    set_lane(1, 2'd1, 6'd1, 1'b1, 6'd1, 1'b1, 64'hB);
    set_lane(2, 2'd1, 6'd1, 1'b1, 6'd1, 1'b1, 64'hC);
    tick();
    clear_inputs();
    set_lane(0, 2'd2, 6'd1, 1'b1, 6'd1, 1'b1, 64'hD);
    tick();
    clear_inputs();
    n_tests++;
    if (issue_valid !== 3'b000) begin
      n_fail++; $display("FAIL budget_zero: got %b expected 000", issue_valid);
    end
    fu_budget = 8'b00_01_01_00;
    tick();
    n_tests++;
    if (issue_valid !== 3'b011 || issue_payload[63:0] !== 64'hA || issue_payload[127:64] !== 64'hD ||
        issue_fu_type[3:2] !== 2'd2 || issue_payload[191:128] !== 64'h0) begin
      n_fail++; $display("FAIL budget_first: valid %b p0 %h p1 %h p2 %h expected 011 a d 0",
                         issue_valid, issue_payload[63:0], issue_payload[127:64], issue_payload[191:128]);
    end
    tick();
    n_tests++;
    if (issue_valid !== 3'b001 || issue_payload[63:0] !== 64'hB) begin
      n_fail++; $display("FAIL budget_second: valid %b p0 %h expected 001 b", issue_valid, issue_payload[63:0]);
    end
    tick();
    n_tests++;
    if (issue_valid !== 3'b001 || issue_payload[63:0] !== 64'hC) begin
      n_fail++; $display("FAIL budget_third: valid %b p0 %h expected 001 c", issue_valid, issue_payload[63:0]);
    end
    tick();
    n_tests++;
    if (issue_valid !== 3'b000 || free_cnt !== 5'd16) begin
      n_fail++; $display("FAIL budget_empty: valid %b free %0d expected 000 16", issue_valid, free_cnt);
    end
  endtask

  task automatic test_cdb_bypass;
    fu_budget = 8'hFF;
    clear_inputs();
    set_lane(0, 2'd3, 6'd9, 1'b0, 6'd3, 1'b1, 64'h900);
    set_lane(1, 2'd3, 6'd10, 1'b0, 6'd3, 1'b1, 64'h901);
    cdb_valid = 3'b100;
    cdb_tag[2*PR_W +: PR_W] = 6'd9;
    tick();
    clear_inputs();
    tick();
    n_tests++;
    if (issue_valid !== 3'b001 || issue_payload[63:0] !== 64'h900 ||
        issue_reg1_pr[5:0] !== 6'd9 || issue_fu_type[1:0] !== 2'd3) begin
      n_fail++; $display("FAIL bypass_issue: valid %b p0 %h pr %0d expected 001 900 9",
                         issue_valid, issue_payload[63:0], issue_reg1_pr[5:0]);
    end
    tick();
    n_tests++;
    if (issue_valid !== 3'b000) begin
      n_fail++; $display("FAIL bypass_waiter_held: got %b expected 000", issue_valid);
    end
    cdb_valid = 3'b010;
    cdb_tag[PR_W +: PR_W] = 6'd10;
    tick();
    clear_inputs();
    n_tests++;
    if (issue_valid !== 3'b000) begin
      n_fail++; $display("FAIL wake_latency: got %b expected 000", issue_valid);
    end
    tick();
    n_tests++;
    if (issue_valid !== 3'b001 || issue_payload[63:0] !== 64'h901 || free_cnt !== 5'd16) begin
      n_fail++; $display("FAIL wake_issue: valid %b p0 %h free %0d expected 001 901 16",
                         issue_valid, issue_payload[63:0], free_cnt);
    end
  endtask

  task automatic test_squash;
    fu_budget = 8'hFF;
    // Squash on the cycle a ready entry would be selected
    clear_inputs();
    set_lane(0, 2'd0, 6'd1, 1'b1, 6'd1, 1'b1, 64'h777);
    tick();
    clear_inputs();
    squash = 1'b1;
    tick();
    clear_inputs();
    n_tests++;
    if (issue_valid !== 3'b000 || free_cnt !== 5'd16) begin
      n_fail++; $display("FAIL squash_pending: valid %b free %0d expected 000 16", issue_valid, free_cnt);
    end
    // Ten waiting entries, then squash with a same-cycle dispatch
    for (int cyc = 0; cyc < 4; cyc++) begin
      clear_inputs();
      for (int k = 0; k < 3; k++)
        if (cyc * 3 + k < 10) set_lane(k, 2'd0, 6'd20, 1'b0, 6'd1, 1'b1, 64'h500 + 64'(cyc * 3 + k));
      tick();
    end
    clear_inputs();
    n_tests++;
    if (free_cnt !== 5'd6) begin
      n_fail++; $display("FAIL squash_fill: got %0d expected 6", free_cnt);
    end
    squash = 1'b1;
    for (int k = 0; k < 3; k++) set_lane(k, 2'd0, 6'd1, 1'b1, 6'd1, 1'b1, 64'hBAD);
    cdb_valid = 3'b001;
    cdb_tag[PR_W-1:0] = 6'd20;
    tick();
    clear_inputs();
    n_tests++;
    if (free_cnt !== 5'd16 || issue_valid !== 3'b000) begin
      n_fail++; $display("FAIL squash_clear: free %0d valid %b expected 16 000", free_cnt, issue_valid);
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      cdb_valid = 3'b001;
      cdb_tag[PR_W-1:0] = 6'd20;
      tick();
      n_tests++;
      if (issue_valid !== 3'b000 || free_cnt !== 5'd16) begin
        n_fail++; $display("FAIL squash_stale cyc%0d: valid %b free %0d expected 000 16", cyc, issue_valid, free_cnt);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_midstream;
    fu_budget = 8'hFF;
    clear_inputs();
    for (int k = 0; k < 3; k++) set_lane(k, 2'd0, 6'd1, 1'b1, 6'd1, 1'b1, 64'h600 + 64'(k));
    tick();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if (issue_valid !== 3'b000 || free_cnt !== 5'd16) begin
      n_fail++; $display("FAIL midreset_clear: valid %b free %0d expected 000 16", issue_valid, free_cnt);
    end
    tick();
    tick();
    n_tests++;
    if (issue_valid !== 3'b000) begin
      n_fail++; $display("FAIL midreset_stale: got %b expected 000", issue_valid);
    end
  endtask

  // Test sequence and final report
  initial begin
    clear_inputs();
    fu_budget = '0;
    test_reset();
    test_dispatch_issue();
    test_full_wakeup();
    test_budget();
    test_cdb_bypass();
    test_squash();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_param.md
# rs_param

Parametrised out-of-order reservation station: holds up to ENTRIES renamed instructions between the dispatch stage and the functional units. It allocates up to DISP_W entries per cycle and wakes sources from a CDB_W-wide tag broadcast. Each cycle it issues up to ISSUE_W ready entries, oldest-first by dispatch order and within a per-FU-type issue budget. It adds true age ordering, valid-gated wakeup, per-type issue budgets and squash relative to the fixed 16-entry, 3-wide station.

## Interface
- ENTRIES, 16, station depth (≥ DISP_W, ≥ 2)
- DISP_W, 3, dispatch lanes; lane 0 is oldest
- ISSUE_W, 3, issue slots; slot 0 carries the oldest issued entry
- CDB_W, 3, wakeup tags per cycle
- PR_W, 6, physical register tag width
- FU_TYPES, 4, number of FU classes; FT_W = clog2(FU_TYPES)
- PAYLOAD_W, 64, opaque per-instruction bits (PC, op, dest, ...), carried unmodified
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; state clears on posedge clock while reset==0
- disp_valid  in  DISP_W  lane k carries an instruction
- disp_fu_type  in  DISP_W*FT_W  FU class per lane
- disp_reg1_pr, disp_reg2_pr  in  DISP_W*PR_W  source tags
- disp_reg1_ready, disp_reg2_ready  in  DISP_W  source already available
- disp_payload  in  DISP_W*PAYLOAD_W  carried bits
- disp_stall  out  DISP_W  lane k must not dispatch this cycle
- cdb_valid  in  CDB_W  broadcast slot valid
- cdb_tag  in  CDB_W*PR_W  completed tags
- fu_budget  in  FU_TYPES*clog2(ISSUE_W+1)  max issues per FU class this cycle
- squash  in  1  flush all entries (branch mispredict)
- issue_valid  out  ISSUE_W  registered issue slot valid
- issue_fu_type, issue_reg1_pr, issue_reg2_pr, issue_payload  out  per-slot widths  registered issued fields
- free_cnt  out  clog2(ENTRIES+1)  free entries, registered

## Operation
- Entry state: valid, fu_type, both tags, both ready bits, payload. Age is kept as an ENTRIES×ENTRIES matrix where older[i][j]=1 means i was dispatched before j.
- Stall: disp_stall[k] = (free_cnt < k+1). This is a combinational function of registered free_cnt only. Entries issuing this cycle are not counted as free.
- Allocation: each non-stalled valid lane takes the lowest-index free entry not taken by a lower-numbered lane. If a lane is asserted while stalled, it is dropped.
- Age on allocation: the new entry becomes younger than every valid entry and every lower-lane same-cycle allocation. Its row and column are rewritten.
- Wakeup: a source ready bit sets when some cdb_valid[c] is 1 and cdb_tag[c] equals the source tag. Invalid CDB slots never match.
- A dispatching source that matches the same-cycle CDB is written as ready.
- Eligibility: the entry is valid, both ready bits are set in the registered state, and it did not issue in the previous cycle.
- A CDB wakeup makes an entry eligible the next cycle; there is no same-cycle wake-and-issue.
- Selection: walk eligible entries oldest-first. An entry is taken if fewer than ISSUE_W have been taken and its FU class has used fewer than fu_budget[class] slots. Otherwise it is skipped, and later entries may still be taken.
- Taken entries fill slots 0..n-1 in age order. Their valid bits clear at the same clock edge, so the entry is reusable for dispatch in the following cycle.
- Squash: when squash=1, all valid bits clear, issue_valid goes to 0 next cycle, and same-cycle dispatch is ignored.
- Priority: reset > squash > normal operation.

## Timing
- Reset values: issue_valid=0, all issue_* = 0, all entry valid=0, age matrix = 0, free_cnt=ENTRIES, disp_stall=0.
- Issue latency: the selection in cycle t is visible on issue_* in cycle t+1.
- Minimum dispatch-to-issue latency is 1 cycle: an entry dispatched with both sources ready at t issues at t+1 and appears on the outputs at t+2.
- free_cnt(t+1) = free_cnt(t) − accepted dispatches + issued entries. After a squash it becomes ENTRIES.
- Full: free_cnt=0 sets all stall bits. An entry issuing in the same cycle does not un-stall dispatch until the next cycle.
- Empty: issue_valid=0 the next cycle; fu_budget is ignored.
- Reset or squash mid-stream: pending issue_* data is discarded. No stale entry issues afterwards.
- Unused issue slots drive 0 on every field.

## Test plan
- Reset low for 2 cycles, then release → free_cnt=16, disp_stall=000, issue_valid=000.
- Dispatch three ALU ops (class 0), all sources ready, fu_budget[0]=3 → two cycles later issue_valid=111 in lane order 0,1,2; free_cnt returns to 16.
- Fill 16 entries, each with reg1 waiting on tag 5, budget 3 → disp_stall=111. Broadcast cdb_valid=001, tag 5 → the three oldest entries issue in the cycle after wakeup. Repeat with cdb_valid=000 and tag 5 → nothing issues.
- Four ready entries (ages A<B<C<D) in classes 1,1,1,2, fu_budget[1]=1, fu_budget[2]=1 → issue is A then D; B and C issue in later cycles.
- Dispatch a source tag 9 while the same cycle broadcasts tag 9 → the entry issues with its ready bit set and no further broadcast.
- Assert squash with 10 valid entries and dispatch on the same cycle → next cycle free_cnt=16, issue_valid=000, and none of those entries ever issue.
